// File: rtl/delta_calc_scheduler.sv
// Round-robin scheduler that time-shares one shortest-path delta calculator
// across the four swerve-wheel rotation channels. Each job snapshots the
// granted wheel's angles, pulses the calculator enable, waits for completion
// (or a timeout), and files the result into that wheel's slot.
module delta_calc_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 31
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  i_req,
  input  logic [47:0] i_target_angle,
  input  logic [47:0] i_current_angle,
  input  logic        i_err_clear,
  output logic        o_calc_enable,
  output logic [11:0] o_calc_target_angle,
  output logic [11:0] o_calc_current_angle,
  input  logic [11:0] i_calc_delta,
  input  logic        i_calc_dir,
  input  logic        i_calc_updated,
  output logic [47:0] o_delta_angle,
  output logic [3:0]  o_dir_shortest,
  output logic [3:0]  o_result_valid,
  output logic [3:0]  o_timeout_err,
  output logic        o_busy,
  output logic [1:0]  o_grant_id
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_e;

  state_e      r_state, w_state_next;
  logic [3:0]  r_pending, w_pending_next;
  logic [1:0]  r_ptr;
  logic [1:0]  r_grant;
  logic [11:0] r_tgt, r_cur;
  logic [4:0]  r_cnt, w_cnt_next;
  logic [47:0] r_delta;
  logic [3:0]  r_dir;
  logic [3:0]  r_err, w_err_next;

  logic        w_found;
  logic [1:0]  w_winner;
  logic        w_grant_en;
  logic        w_store;
  logic        w_timeout;

  // Round-robin search: lowest offset from ptr among pending wheels wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[2'(r_ptr + 2'(i))]) begin
        w_found  = 1'b1;
        w_winner = 2'(r_ptr + 2'(i));
      end
    end
  end

  // Next-state and job-control decode.
  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    w_store      = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_en   = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_cnt_next   = '0;
        w_state_next = StWait;
      end
      StWait: begin
        if (i_calc_updated) begin
          w_store      = 1'b1;
          w_state_next = StStore;
        end else if (r_cnt == 5'(TIMEOUT_CYCLES)) begin
          w_timeout    = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 5'd1;
        end
      end
      StStore: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // A request in the grant cycle re-arms the wheel (set beats clear);
  // a timeout in the same cycle as err_clear survives.
  always_comb begin
    w_pending_next = (r_pending & ~(w_grant_en ? (4'b0001 << w_winner) : 4'b0000)) | i_req;
    w_err_next     = (i_err_clear ? 4'b0000 : r_err)
                   | (w_timeout ? (4'b0001 << r_grant) : 4'b0000);
  end

  // State, pointer, pending bits, timeout counter and error flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_pending <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_err     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_cnt     <= w_cnt_next;
      r_err     <= w_err_next;
      if (w_grant_en) r_ptr <= w_winner + 2'd1;
    end
  end

  // Grant snapshot: held until the next grant so mid-job input changes are ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_grant <= '0;
      r_tgt   <= '0;
      r_cur   <= '0;
    end else if (w_grant_en) begin
      r_grant <= w_winner;
      r_tgt   <= i_target_angle[12*w_winner +: 12];
      r_cur   <= i_current_angle[12*w_winner +: 12];
    end
  end

  // Per-wheel result slots, written only on a completed job.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_delta <= '0;
      r_dir   <= '0;
    end else if (w_store) begin
      r_delta[12*r_grant +: 12] <= i_calc_delta;
      r_dir[r_grant]            <= i_calc_dir;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    o_calc_enable        = (r_state == StIssue);
    o_busy               = (r_state != StIdle);
    o_result_valid       = (r_state == StStore) ? (4'b0001 << r_grant) : 4'b0000;
    o_calc_target_angle  = r_tgt;
    o_calc_current_angle = r_cur;
    o_delta_angle        = r_delta;
    o_dir_shortest       = r_dir;
    o_timeout_err        = r_err;
    o_grant_id           = r_grant;
  end

endmodule

// File: tb/tb_delta_calc_scheduler.sv
// Bench for delta_calc_scheduler: a behavioural calculator stub answers each
// enable pulse eight cycles later, and a scoreboard of expected per-wheel
// results (wheel, delta, direction, arrival cycle) is checked on result_valid.
module tb_delta_calc_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [47:0] tgt, cur;
  logic        err_clear;
  logic        calc_enable;
  logic [11:0] calc_tgt, calc_cur;
  logic [11:0] calc_delta;
  logic        calc_dir;
  logic        calc_updated;
  logic [47:0] delta_angle;
  logic [3:0]  dir_shortest, result_valid, timeout_err;
  logic        busy;
  logic [1:0]  grant_id;

  logic stub_on, stub_upd, force_upd;
  assign calc_updated = stub_upd | force_upd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          w;
    logic [11:0] delta;
    logic        dir;
    int          at;
  } exp_t;
  exp_t sb[$];

  delta_calc_scheduler #(.TIMEOUT_CYCLES(31)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .i_req                (req),
    .i_target_angle       (tgt),
    .i_current_angle      (cur),
    .i_err_clear          (err_clear),
    .o_calc_enable        (calc_enable),
    .o_calc_target_angle  (calc_tgt),
    .o_calc_current_angle (calc_cur),
    .i_calc_delta         (calc_delta),
    .i_calc_dir           (calc_dir),
    .i_calc_updated       (calc_updated),
    .o_delta_angle        (delta_angle),
    .o_dir_shortest       (dir_shortest),
    .o_result_valid       (result_valid),
    .o_timeout_err        (timeout_err),
    .o_busy               (busy),
    .o_grant_id           (grant_id)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Shortest path on a 4096-point circle: dir 0 when target is ahead of current.
  function automatic logic [12:0] shortest(input logic [11:0] t, input logic [11:0] c);
    logic [11:0] d;
    logic [11:0] z;
    z = 12'd0;
    d = t - c;
    if (d <= 12'd2048) return {1'b0, d};
    return {1'b1, z - d};
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic set_wheel(input int w, input logic [11:0] t, input logic [11:0] c);
    tgt[12*w +: 12] = t;
    cur[12*w +: 12] = c;
  endtask

  task automatic push(input int w, input logic [11:0] t, input logic [11:0] c, input int at);
    exp_t e;
    logic [12:0] r;
    r       = shortest(t, c);
    e.w     = w;
    e.delta = r[11:0];
    e.dir   = r[12];
    e.at    = at;
    sb.push_back(e);
  endtask

  // Calculator stub: samples the snapshot on enable, pulses updated 8 cycles later.
  initial begin
    int          scnt;
    logic [11:0] lt, lc;
    logic        prev_en;
    scnt = 0; lt = '0; lc = '0; prev_en = 1'b0;
    stub_upd = 1'b0; calc_delta = '0; calc_dir = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        scnt = 0; stub_upd = 1'b0; prev_en = 1'b0;
      end else begin
        check("enable_single_cycle", {47'd0, prev_en & calc_enable}, 48'd0);
        prev_en  = calc_enable;
        stub_upd = 1'b0;
        if (scnt > 0) begin
          scnt--;
          if (scnt == 0) begin
            stub_upd = 1'b1;
            {calc_dir, calc_delta} = shortest(lt, lc);
          end
        end
        if (stub_on && calc_enable === 1'b1) begin
          scnt = 8; lt = calc_tgt; lc = calc_cur;
        end
      end
    end
  end

  // Scoreboard monitor: every result_valid pulse must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && result_valid !== 4'b0000) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {44'd0, result_valid}, 48'd0);
        end else begin
          e = sb.pop_front();
          check("valid_onehot", {44'd0, result_valid}, {44'd0, 4'b0001 << e.w});
          check("slot_delta", {36'd0, delta_angle[12*e.w +: 12]}, {36'd0, e.delta});
          check("slot_dir", {47'd0, dir_shortest[e.w]}, {47'd0, e.dir});
          check("valid_cycle", 48'(cyc), 48'(e.at));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    repeat (5000) @(posedge clock);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int t0;
    reset_n = 1'b0; req = '0; tgt = '0; cur = '0; err_clear = 1'b0;
    stub_on = 1'b1; force_upd = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", {47'd0, busy}, 48'd0);
    check("rst_enable", {47'd0, calc_enable}, 48'd0);
    check("rst_outputs", {delta_angle}, 48'd0);
    check("rst_flags", {36'd0, dir_shortest, result_valid, timeout_err}, 48'd0);
    check("rst_snapshot", {22'd0, grant_id, calc_tgt, calc_cur}, 48'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // All four wheels at once from ptr 0: served 0,1,2,3 every 11 cycles.
    set_wheel(0, 12'd10, 12'd20);
    set_wheel(1, 12'd2000, 12'd0);
    set_wheel(2, 12'd0, 12'd1000);
    set_wheel(3, 12'd4095, 12'd1);
    t0 = cyc;
    req = 4'b1111;
    push(0, 12'd10, 12'd20, t0 + 11);
    push(1, 12'd2000, 12'd0, t0 + 22);
    push(2, 12'd0, 12'd1000, t0 + 33);
    push(3, 12'd4095, 12'd1, t0 + 44);
    @(negedge clock);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      goto(t0 + 2 + 11 * i);
      check("rr_enable", {47'd0, calc_enable}, 48'd1);
      check("rr_grant", {46'd0, grant_id}, 48'(i));
    end
    goto(t0 + 45);
    check("rr_idle", {47'd0, busy}, 48'd0);
    check("rr_drained", 48'(sb.size()), 48'd0);

    // Single request, wheel 2: 100 vs 4000 gives delta 196, dir 0.
    set_wheel(2, 12'd100, 12'd4000);
    t0 = cyc;
    req = 4'b0100;
    push(2, 12'd100, 12'd4000, t0 + 11);
    @(negedge clock);
    req = 4'b0000;
    check("single_idle_c1", {47'd0, busy}, 48'd0);
    goto(t0 + 2);
    check("single_enable_c2", {47'd0, calc_enable}, 48'd1);
    check("single_snap", {24'd0, calc_tgt, calc_cur}, {24'd0, 12'd100, 12'd4000});
    goto(t0 + 3);
    check("single_enable_c3", {47'd0, calc_enable}, 48'd0);
    goto(t0 + 12);
    check("single_done", {47'd0, busy}, 48'd0);
    check("single_slot", {36'd0, delta_angle[35:24]}, 48'd196);

    // Fairness: wheel 0 held, wheel 3 pulsed mid-job -> order 0, 3, 0.
    set_wheel(0, 12'd300, 12'd100);
    set_wheel(3, 12'd50, 12'd4000);
    t0 = cyc;
    req = 4'b0001;
    push(0, 12'd300, 12'd100, t0 + 11);
    push(3, 12'd50, 12'd4000, t0 + 22);
    push(0, 12'd300, 12'd100, t0 + 33);
    goto(t0 + 2);
    req = 4'b1001;
    @(negedge clock);
    req = 4'b0001;
    goto(t0 + 13);
    check("fair_grant_w3", {46'd0, grant_id}, 48'd3);
    req = 4'b0000;
    goto(t0 + 24);
    check("fair_grant_w0", {46'd0, grant_id}, 48'd0);
    goto(t0 + 36);
    check("fair_idle", {47'd0, busy}, 48'd0);

    // Mid-job input change on wheel 1 is not seen by the calculator.
    set_wheel(1, 12'd500, 12'd100);
    t0 = cyc;
    req = 4'b0010;
    push(1, 12'd500, 12'd100, t0 + 11);
    @(negedge clock);
    req = 4'b0000;
    goto(t0 + 5);
    set_wheel(1, 12'd900, 12'd100);
    goto(t0 + 6);
    check("hold_snapshot", {36'd0, calc_tgt}, 48'd500);
    goto(t0 + 12);
    check("hold_slot", {36'd0, delta_angle[23:12]}, 48'd400);

    // Timeout: no completion for wheel 3 -> err after 32 WAIT cycles.
    stub_on = 1'b0;
    t0 = cyc;
    req = 4'b1000;
    @(negedge clock);
    req = 4'b0000;
    goto(t0 + 34);
    check("to_still_waiting", {43'd0, busy, timeout_err}, {43'd0, 1'b1, 4'b0000});
    goto(t0 + 35);
    check("to_err_set", {44'd0, timeout_err}, 48'h8);
    check("to_back_idle", {47'd0, busy}, 48'd0);
    check("to_slot_kept", {36'd0, delta_angle[47:36]}, 48'd146);
    goto(t0 + 36);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    check("to_err_cleared", {44'd0, timeout_err}, 48'd0);
    stub_on = 1'b1;

    // Reset in WAIT abandons the job; a stale completion afterwards is ignored.
    set_wheel(0, 12'd1234, 12'd34);
    t0 = cyc;
    req = 4'b0001;
    @(negedge clock);
    req = 4'b0000;
    goto(t0 + 5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy_en", {46'd0, busy, calc_enable}, 48'd0);
    check("mid_rst_slots", delta_angle, 48'd0);
    check("mid_rst_flags", {36'd0, dir_shortest, result_valid, timeout_err}, 48'd0);
    check("mid_rst_snap", {22'd0, grant_id, calc_tgt, calc_cur}, 48'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    goto(t0 + 10);
    force_upd = 1'b1;
    @(negedge clock);
    force_upd = 1'b0;
    goto(t0 + 15);
    check("post_rst_idle", {47'd0, busy}, 48'd0);
    check("post_rst_slots", {delta_angle}, 48'd0);
    check("post_rst_no_grant", {36'd0, calc_tgt}, 48'd0);
    check("sb_empty", 48'(sb.size()), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delta_calc_scheduler.md
# delta_calc_scheduler

Round-robin scheduler sharing one shortest-path delta calculator among the four swerve-wheel rotation channels. Latches per-wheel recalculation requests, snapshots the winning wheel's target/current angles onto the calculator inputs, pulses its enable, waits for its completion pulse, and files the delta/direction result into that wheel's result slot. Sits between the per-wheel rotation controllers and the single delta calculator instance in the subsystem.

## Interface
- TIMEOUT_CYCLES, 31: max cycles in WAIT before the job is aborted; counter width 5 bits, legal range 12..31.
- clock  in  1  main clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  4  per-wheel recalculation request; any cycle high sets that wheel's pending bit
- target_angle  in  48  wheel w target at [12w+11:12w], 4096 points/rotation
- current_angle  in  48  wheel w encoder angle at [12w+11:12w]
- err_clear  in  1  clears all timeout_err bits
- calc_enable  out  1  enable to calculator, one-cycle pulse per job
- calc_target_angle  out  12  snapshot target of granted wheel
- calc_current_angle  out  12  snapshot current angle of granted wheel
- calc_delta  in  12  calculator delta result
- calc_dir  in  1  calculator shortest direction (1 CCW, 0 CW)
- calc_updated  in  1  calculator completion pulse
- delta_angle  out  48  per-wheel stored delta, slot [12w+11:12w]
- dir_shortest  out  4  per-wheel stored direction
- result_valid  out  4  one-cycle pulse, bit w, when slot w is updated
- timeout_err  out  4  sticky per-wheel timeout flag
- busy  out  1  high in any state other than IDLE
- grant_id  out  2  wheel currently (or last) being serviced

## Operation
- pending[3:0]: set by req[w]; cleared for the granted wheel on grant. req[w] high on the grant cycle of wheel w keeps pending[w] set (set wins over clear).
- Round-robin pointer ptr[1:0]: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first pending bit wins; ptr <= winner+1 (mod 4) on grant.
- States: IDLE, ISSUE, WAIT, STORE.
  - IDLE: if pending != 0, grant winner: latch grant_id, calc_target_angle, calc_current_angle from that wheel's slices; clear pending bit; -> ISSUE. Else stay.
  - ISSUE: calc_enable = 1 this cycle only; clear timeout counter; -> WAIT.
  - WAIT: calc_enable = 0. On calc_updated: capture calc_delta/calc_dir into slot grant_id; -> STORE. Else increment counter; when counter == TIMEOUT_CYCLES, set timeout_err[grant_id], slot unchanged, no result_valid; -> IDLE.
  - STORE: result_valid[grant_id] = 1; -> IDLE.
- calc_target_angle/calc_current_angle held constant from grant until the next grant; input changes during a job are ignored.
- calc_updated outside WAIT is ignored (calculator's pulse is unreset and may be X after reset).
- err_clear clears timeout_err; a timeout set in the same cycle wins.
- Reset: state IDLE, ptr 0, pending 0, all outputs 0, counter 0. Reset mid-job abandons it; no result_valid generated.

## Timing
- req at cycle 0 -> pending set edge end 0 -> IDLE grants cycle 1 -> calc_enable high cycle 2.
- Calculator: IDLE samples enable end of cycle 2, CALC_DELTA 3, CALC_MIN 4-7, REPORT 8, UPDATED 9, calc_updated high cycle 10.
- WAIT captures cycle 10, STORE cycle 11: result_valid and new slot value visible cycle 11; IDLE cycle 12 (next grant possible).
- Job period 11 cycles back-to-back; four simultaneous requests complete in 44 cycles.
- Timeout: counter increments every WAIT cycle without calc_updated; abort after TIMEOUT_CYCLES+1 WAIT cycles.
- calc_enable never high for two consecutive cycles; never high outside ISSUE.

## Test plan
- Single request: req=4'b0100 one cycle, wheel 2 target 100, current 4000 -> calc_enable cycle 2, result_valid=4'b0100 cycle 11, delta_angle[35:24]=196, dir_shortest[2]=0.
- All four requested same cycle, ptr=0 -> grants in order 0,1,2,3, result_valid pulses at 11, 22, 33, 44; ptr ends at 0.
- Fairness: wheel 0 requested continuously, wheel 3 requested once -> after wheel 0 served, wheel 3 served next, not wheel 0 twice.
- Input change mid-job: wheel 1 target changes 500->900 during WAIT -> calc_target_angle stays 500, stored delta based on 500.
- Timeout: calculator stubbed never pulsing calc_updated -> timeout_err[w]=1 after 32 WAIT cycles, no result_valid, returns IDLE; err_clear then clears it.
- Reset asserted during WAIT -> all outputs 0 immediately, pending cleared, stale calc_updated after release ignored.
